// File: rtl/task_6_output_pkg.sv
// rtl/task_6_output_pkg.sv - shared types and defaults for the task 6 output stage
package task_6_output_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int CNT_W_DEF  = 9;

    typedef enum logic [1:0] {
        s_IDLE,
        s_SEND,
        s_GAP
    } state_t;

    // FIFO word layout: last flag in the MSB above the data byte
    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/task_6_output_fifo.sv
// rtl/task_6_output_fifo.sv - single-clock show-ahead FIFO with synchronous clear
module task_6_output_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match
    assign q     = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/task_6_output.sv
// rtl/task_6_output.sv - packet-buffered AXI-Stream output stage; TASK6_OUT_PKT_CNT_EN adds o_pkt_cnt
module task_6_output
    import task_6_output_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_tvalid,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    input  logic              i_tready,
    output logic              o_busy,
    output logic              o_empty,
    output logic              o_overflow
`ifdef TASK6_OUT_PKT_CNT_EN
    ,
    output logic [15:0]       o_pkt_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             full;
    logic             empty;
    logic [DATA_W:0]  head;
    logic             head_last;
    logic             wr_en;
    logic             handshake;
    logic             pkt_in;
    logic             pkt_out;
    logic [CNT_W-1:0] pkt_ready;

    assign wr_en     = i_valid && !full;
    assign handshake = o_tvalid && i_tready;
    assign head_last = head[DATA_W];
    assign pkt_in    = wr_en && i_last;
    assign pkt_out   = handshake && head_last;

    task_6_output_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (wr_en),
        .wr_data ({i_last, i_data}),
        .rd_en   (handshake),
        .q       (head),
        .empty   (empty),
        .full    (full)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_ready <= '0;
        end else if (pkt_in && !pkt_out) begin
            pkt_ready <= pkt_ready + CNT_W'(1);
        end else if (pkt_out && !pkt_in) begin
            pkt_ready <= pkt_ready - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (i_valid && full) begin
            o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= s_IDLE;
        else       state <= state_nxt;
    end

    // A full FIFO with no complete packet means an oversize packet: start cut-through
    always_comb begin
        state_nxt = state;
        o_tvalid  = 1'b0;
        case (state)
            s_IDLE: begin
                if (pkt_ready != '0 || full) state_nxt = s_SEND;
            end
            s_SEND: begin
                o_tvalid = !empty;
                if (!empty && i_tready && head_last) state_nxt = s_GAP;
            end
            s_GAP:   state_nxt = s_IDLE;
            default: state_nxt = s_IDLE;
        endcase
    end

    assign o_tdata = o_tvalid ? head[DATA_W-1:0] : '0;
    assign o_tlast = o_tvalid && head_last;
    assign o_ready = !full;
    assign o_empty = empty;
    assign o_busy  = (state != s_IDLE);

`ifdef TASK6_OUT_PKT_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)        o_pkt_cnt <= 16'd0;
        else if (pkt_out) o_pkt_cnt <= o_pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_task_6_output.sv
// tb/tb_task_6_output.sv - directed self-checking bench for task_6_output (DEPTH=16)
module tb_task_6_output;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       last = 1'b0;
    logic       ready;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;
    logic       tready = 1'b0;
    logic       busy;
    logic       empty;
    logic       overflow;
`ifdef TASK6_OUT_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] wq[$];
    logic [7:0] rx_data[$];
    logic       rx_last[$];
    int         rx_cyc[$];
    int         rx_timeout;
    int         stab_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task_6_output #(
        .DATA_W (8),
        .DEPTH  (16),
        .CNT_W  (9)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_data     (data),
        .i_last     (last),
        .o_ready    (ready),
        .o_tvalid   (tvalid),
        .o_tdata    (tdata),
        .o_tlast    (tlast),
        .i_tready   (tready),
        .o_busy     (busy),
        .o_empty    (empty),
        .o_overflow (overflow)
`ifdef TASK6_OUT_PKT_CNT_EN
        ,
        .o_pkt_cnt  (pkt_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pushes wq into the DUT, writing only when o_ready is high
    task automatic send_wq(input int budget);
        int k = 0;
        while (wq.size() > 0 && k < budget) begin
            if (ready) begin
                valid = 1'b1;
                {last, data} = wq[0];
            end else begin
                valid = 1'b0;
            end
            tick;
            if (valid) void'(wq.pop_front());
            k++;
        end
        valid = 1'b0;
        last  = 1'b0;
        data  = 8'h00;
    endtask

    // Sink: mode 0 = tready always 1, mode 1 = 1,0,1,0...
    task automatic rx(input int nlast, input int max_beats, input int mode, input int budget);
        int k = 0;
        logic pv = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        rx_timeout = 0;
        stab_err = 0;
        while (nlast > 0 && rx_data.size() < max_beats) begin
            if (k >= budget) begin
                rx_timeout = 1;
                break;
            end
            tready = (mode == 0) ? 1'b1 : (k % 2 == 0);
            if (pv && (tvalid !== 1'b1 || tdata !== pd || tlast !== pl)) stab_err++;
            pv = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            if (tvalid && tready) begin
                rx_data.push_back(tdata);
                rx_last.push_back(tlast);
                rx_cyc.push_back(cyc);
                if (tlast) nlast--;
            end
            tick;
            k++;
        end
        tready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({tvalid, tdata, tlast, busy, overflow, empty, ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL reset_values got tv=%b td=%h tl=%b busy=%b ovf=%b empty=%b ready=%b want 0 00 0 0 0 1 1",
                     tvalid, tdata, tlast, busy, overflow, empty, ready);
        end
`ifdef TASK6_OUT_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errs++;
            $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt);
        end
`endif
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        wq = {9'h011, 9'h022, 9'h033, 9'h144};
        send_wq(20);
        checks++;
        if (tvalid !== 1'b0) begin
            errs++;
            $display("FAIL single_lat_n1 tvalid got %b want 0", tvalid);
        end
        tick;
        checks++;
        if (tvalid !== 1'b1 || tdata !== 8'h11) begin
            errs++;
            $display("FAIL single_lat_n2 got tv=%b td=%h want 1 11", tvalid, tdata);
        end
        rx(1, 10, 0, 20);
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 4) begin
            errs++;
            $display("FAIL single_count got %0d beats timeout=%0d want 4", rx_data.size(), rx_timeout);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_data[i] !== 8'(8'h11 * (i + 1)) || rx_last[i] !== (i == 3)) begin
                    errs++;
                    $display("FAIL single_beat%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                             8'(8'h11 * (i + 1)), (i == 3));
                end
            end
            checks++;
            if (rx_cyc[3] - rx_cyc[0] != 3) begin
                errs++;
                $display("FAIL single_b2b span got %0d want 3", rx_cyc[3] - rx_cyc[0]);
            end
        end
        checks++;
        if (busy !== 1'b1 || tvalid !== 1'b0) begin
            errs++;
            $display("FAIL single_gap got busy=%b tv=%b want 1 0", busy, tvalid);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL single_idle busy got %b want 0", busy);
        end
`ifdef TASK6_OUT_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errs++;
            $display("FAIL single_pkt_cnt got %0d want 1", pkt_cnt);
        end
`endif
    endtask

    task automatic test_backpressure;
        wq = {9'h011, 9'h022, 9'h033, 9'h144};
        send_wq(20);
        rx(1, 10, 1, 40);
        checks++;
        if (stab_err != 0) begin
            errs++;
            $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err);
        end
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 4) begin
            errs++;
            $display("FAIL bp_count got %0d beats timeout=%0d want 4", rx_data.size(), rx_timeout);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_data[i] !== 8'(8'h11 * (i + 1)) || rx_last[i] !== (i == 3)) begin
                    errs++;
                    $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                             8'(8'h11 * (i + 1)), (i == 3));
                end
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d[5];
        logic       exp_l[5];
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        wq = {9'h0A1, 9'h0A2, 9'h1A3, 9'h0B1, 9'h1B2};
        fork
            send_wq(20);
            rx(2, 10, 0, 40);
        join
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 5) begin
            errs++;
            $display("FAIL b2b_count got %0d beats timeout=%0d want 5", rx_data.size(), rx_timeout);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_data[i] !== exp_d[i] || rx_last[i] !== exp_l[i]) begin
                    errs++;
                    $display("FAIL b2b_beat%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_d[i], exp_l[i]);
                end
            end
            checks++;
            if (rx_cyc[3] - rx_cyc[2] != 3) begin
                errs++;
                $display("FAIL b2b_gap A3->B1 got %0d cycles want 3", rx_cyc[3] - rx_cyc[2]);
            end
        end
        tick;
        tick;
        tick;
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            errs++;
            $display("FAIL b2b_settle got busy=%b empty=%b want 0 1", busy, empty);
        end
    endtask

    task automatic test_oversize;
        for (int i = 1; i <= 16; i++) wq.push_back({1'b0, 8'(8'h80 + i)});
        send_wq(40);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL over_full got ready=%b busy=%b want 0 0", ready, busy);
        end
        tick;
        checks++;
        if (busy !== 1'b1 || tvalid !== 1'b1 || tdata !== 8'h81 || tlast !== 1'b0) begin
            errs++;
            $display("FAIL over_cut got busy=%b tv=%b td=%h tl=%b want 1 1 81 0", busy, tvalid, tdata, tlast);
        end
        for (int i = 17; i <= 20; i++) wq.push_back({(i == 20), 8'(8'h80 + i)});
        fork
            send_wq(100);
            rx(1, 40, 0, 200);
        join
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 20) begin
            errs++;
            $display("FAIL over_count got %0d beats timeout=%0d want 20", rx_data.size(), rx_timeout);
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rx_data[i] !== 8'(8'h81 + i) || rx_last[i] !== (i == 19)) begin
                    errs++;
                    $display("FAIL over_beat%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i], 8'(8'h81 + i), (i == 19));
                end
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL over_no_ovf got %b want 0", overflow);
        end
        tick;
        tick;
    endtask

    task automatic test_overflow;
        int seen_ee = 0;
        for (int i = 1; i <= 16; i++) wq.push_back({1'b0, 8'(8'h60 + i)});
        send_wq(40);
        valid = 1'b1;
        data  = 8'hEE;
        last  = 1'b0;
        tick;
        valid = 1'b0;
        data  = 8'h00;
        checks++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_set got %b want 1", overflow);
        end
        wq = {9'h171};
        fork
            send_wq(100);
            rx(1, 40, 0, 200);
        join
        foreach (rx_data[i]) if (rx_data[i] === 8'hEE) seen_ee++;
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 17 || seen_ee != 0) begin
            errs++;
            $display("FAIL ovf_drain got %0d beats ee=%0d timeout=%0d want 17 0 0", rx_data.size(), seen_ee, rx_timeout);
        end else begin
            checks++;
            if (rx_data[16] !== 8'h71 || rx_last[16] !== 1'b1) begin
                errs++;
                $display("FAIL ovf_tail got %h/%b want 71/1", rx_data[16], rx_last[16]);
            end
        end
        tick;
        checks++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_sticky got %b want 1", overflow);
        end
    endtask

    task automatic test_mid_reset;
        wq = {9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
        send_wq(20);
        rx(1, 2, 0, 20);
        checks++;
        if (rx_data.size() != 2) begin
            errs++;
            $display("FAIL mrst_partial got %0d beats want 2", rx_data.size());
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({tvalid, empty, busy, overflow, tlast} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL mrst_state got tv=%b empty=%b busy=%b ovf=%b tl=%b want 0 1 0 0 0",
                     tvalid, empty, busy, overflow, tlast);
        end
        wq = {9'h15A};
        send_wq(10);
        rx(1, 10, 0, 20);
        checks++;
        if (rx_timeout != 0 || rx_data.size() != 1) begin
            errs++;
            $display("FAIL mrst_new_count got %0d beats timeout=%0d want 1", rx_data.size(), rx_timeout);
        end else begin
            checks++;
            if (rx_data[0] !== 8'h5A || rx_last[0] !== 1'b1) begin
                errs++;
                $display("FAIL mrst_new_beat got %h/%b want 5a/1", rx_data[0], rx_last[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_oversize;
        test_overflow;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
